// File: rtl/bus_pkg.sv
// Shared constants for the datapath bus: default word width, source
// index map of the register file / special registers, and arbitration modes.
package bus_pkg;

    localparam int BUS_WIDTH = 32;
    localparam int DEF_NSRC  = 24;
    localparam int DEF_CNTW  = 8;

    // Source indices on the shared bus.
    localparam int unsigned R0  = 0,  R1  = 1,  R2  = 2,  R3  = 3;
    localparam int unsigned R4  = 4,  R5  = 5,  R6  = 6,  R7  = 7;
    localparam int unsigned R8  = 8,  R9  = 9,  R10 = 10, R11 = 11;
    localparam int unsigned R12 = 12, R13 = 13, R14 = 14, R15 = 15;
    localparam int unsigned HI     = 16;
    localparam int unsigned LO     = 17;
    localparam int unsigned ZHI    = 18;
    localparam int unsigned ZLO    = 19;
    localparam int unsigned PC     = 20;
    localparam int unsigned MDR    = 21;
    localparam int unsigned INPORT = 22;
    localparam int unsigned C      = 23;

    typedef enum logic {
        MODE_PRIO = 1'b0,
        MODE_RR   = 1'b1
    } mode_e;

endpackage

// File: rtl/bus_mux_arbiter_if.sv
// Source-side requests and the registered shared-bus outputs of the arbiter.
interface bus_mux_arbiter_if
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int SELW  = $clog2(NSRC),
    parameter int CNTW  = DEF_CNTW
) ();

    logic [NSRC*WIDTH-1:0] src_data;
    logic [NSRC-1:0]       src_out;
    logic                  mode;
    logic                  cnt_clr;
    logic [WIDTH-1:0]      bus_out;
    logic                  bus_valid;
    logic [NSRC-1:0]       grant;
    logic [SELW-1:0]       sel;
    logic                  conflict;
    logic [CNTW-1:0]       conflict_count;

    // Driver side: sources and control.
    modport master (
        output src_data, src_out, mode, cnt_clr,
        input  bus_out, bus_valid, grant, sel, conflict, conflict_count
    );

    // Arbiter side.
    modport slave (
        input  src_data, src_out, mode, cnt_clr,
        output bus_out, bus_valid, grant, sel, conflict, conflict_count
    );

endinterface

// File: rtl/bus_mux_arbiter_picker.sv
// Combinational winner selection: lowest index in priority mode, or first
// request found searching upward from ptr+1 (wrapping) in round-robin mode.
module rr_priority_picker
    import bus_pkg::*;
#(
    parameter int NSRC = DEF_NSRC,
    parameter int SELW = $clog2(NSRC)
) (
    input  logic [NSRC-1:0] req_i,
    input  logic [SELW-1:0] ptr_i,
    input  logic            mode_i,
    output logic [NSRC-1:0] onehot_o,
    output logic [SELW-1:0] idx_o,
    output logic            any_o,
    output logic            multi_o
);

    assign any_o    = |req_i;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o  = |(req_i & (req_i - NSRC'(1)));
    assign onehot_o = any_o ? (NSRC'(1) << idx_o) : '0;

    // Scan candidates in search order and keep the first requested one.
    always_comb begin
        logic            found;
        logic [SELW-1:0] pos;
        // NOTE: every variable gets a default before the loop so no path can infer a latch.
        found = 1'b0;
        pos   = '0;
        idx_o = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (mode_i == MODE_RR) begin
                pos = SELW'((int'(ptr_i) + 1 + k) % NSRC);
            end else begin
                pos = SELW'(k);
            end
            if (!found && req_i[pos]) begin
                found = 1'b1;
                idx_o = pos;
            end
        end
    end

endmodule

// File: rtl/bus_mux_arbiter.sv
// Registered shared-bus multiplexer with conflict arbitration, a conflict
// pulse and a saturating conflict counter. Idle cycles keep the last bus value.
module bus_mux_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH = BUS_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int SELW  = $clog2(NSRC),
    parameter int CNTW  = DEF_CNTW
) (
    input  logic              clock,
    input  logic              clear,
    bus_mux_arbiter_if.slave  bus
);

    logic [NSRC-1:0]  pick_onehot;
    logic [SELW-1:0]  pick_idx;
    logic             pick_any;
    logic             pick_multi;
    logic [WIDTH-1:0] pick_word;

    logic [WIDTH-1:0] bus_out_q,   bus_out_d;
    logic             bus_valid_q, bus_valid_d;
    logic [NSRC-1:0]  grant_q,     grant_d;
    logic [SELW-1:0]  sel_q,       sel_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic             conflict_q,  conflict_d;
    logic [CNTW-1:0]  count_q,     count_d;

    rr_priority_picker #(
        .NSRC (NSRC),
        .SELW (SELW)
    ) u_picker (
        .req_i    (bus.src_out),
        .ptr_i    (rr_ptr_q),
        .mode_i   (bus.mode),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any),
        .multi_o  (pick_multi)
    );

    assign pick_word = bus.src_data[pick_idx*WIDTH +: WIDTH];

    // Next-state: load the winner, keep bus/sel/pointer when idle, count conflicts.
    always_comb begin
        bus_out_d   = bus_out_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        bus_valid_d = pick_any;
        grant_d     = pick_onehot;
        conflict_d  = pick_multi;
        count_d     = count_q;
        if (pick_any) begin
            bus_out_d = pick_word;
            sel_d     = pick_idx;
            rr_ptr_d  = pick_idx;
        end
        if (bus.cnt_clr) begin
            count_d = '0;
        end else if (pick_multi && (count_q != '1)) begin
            count_d = count_q + CNTW'(1);
        end
    end

    // State registers; pointer resets to the last index so round-robin starts at 0.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            grant_q     <= '0;
            sel_q       <= '0;
            rr_ptr_q    <= SELW'(NSRC - 1);
            conflict_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking so every register takes its pre-edge _d value together.
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            conflict_q  <= conflict_d;
            count_q     <= count_d;
        end
    end

    assign bus.bus_out        = bus_out_q;
    assign bus.bus_valid      = bus_valid_q;
    assign bus.grant          = grant_q;
    assign bus.sel            = sel_q;
    assign bus.conflict       = conflict_q;
    assign bus.conflict_count = count_q;

endmodule

// File: doc/bus_mux_arbiter.md
# bus_mux_arbiter

Parametrised, registered successor to the datapath bus multiplexer. It takes NSRC source words and one-hot source drive requests (the per-register "out" strobes), picks one source, and drives a registered shared bus. It resolves multi-driver conflicts by fixed priority or round-robin, and reports them with a pulse and a saturating counter. It sits between the register file, special registers and the bus, and replaces the encoder-plus-mux pair.

## Interface
- WIDTH, 32, bus and source word width
- NSRC, 24, number of sources (2..64)
- SELW, $clog2(NSRC), width of encoded select
- CNTW, 8, conflict counter width
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- src_data  in  NSRC*WIDTH  packed source words; source i at [i*WIDTH +: WIDTH]
- src_out  in  NSRC  drive requests, one bit per source; nominally one-hot
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- cnt_clr  in  1  synchronous clear of conflict_count
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  bus_out was loaded from a granted source this cycle
- grant  out  NSRC  registered one-hot grant, all zero when idle
- sel  out  SELW  registered encoded index of the last grant
- conflict  out  1  one-cycle pulse: previous sample had ≥2 requests
- conflict_count  out  CNTW  saturating count of conflicts

## Operation
- Each rising edge samples src_out and src_data.
- Zero requests:
  - bus_out holds its previous value (bus-keeper behaviour).
  - bus_valid=0, grant=0.
  - sel and rr_ptr unchanged.
- Exactly one request i:
  - bus_out=src_data[i], bus_valid=1, grant=1<<i, sel=i.
  - Applies in both modes.
- Two or more requests:
  - mode 0: lowest set index wins.
  - mode 1: first set index searching upward from rr_ptr+1, wrapping NSRC-1→0.
  - conflict=1 for one cycle; conflict_count increments, saturating at 2^CNTW-1.
- rr_ptr (internal, SELW bits) updates to the winning index on every grant in either mode. It is therefore retained across mode changes. A mode change takes effect at the next sample.
- cnt_clr=1 zeroes conflict_count at the edge. It wins over a simultaneous increment; the conflict pulse still asserts.
- Reset values:
  - bus_out=0, bus_valid=0, grant=0, sel=0, conflict=0, conflict_count=0.
  - rr_ptr=NSRC-1, so the first round-robin search starts at index 0.
- Reset asserted mid-operation forces all of the above immediately, independent of clock. The first sample after deassertion is treated as fresh.
- Width: sources are equal width, with no extension or truncation. grant and sel always agree when bus_valid=1.

## Timing
- Latency 1: requests sampled at edge N appear on bus_out/grant/sel/conflict after edge N.
- No combinational path from any input to any output.
- conflict is high for exactly one cycle per conflicting sample; back-to-back conflicts keep it high continuously.
- The round-robin pointer used at edge N is the value produced at edge N-1. Consecutive conflicting samples therefore rotate.
- Saturation: at count 2^CNTW-1, further conflicts leave the count unchanged and still pulse conflict.

## Structure
- Shared package bus_pkg:
  - default WIDTH
  - source index constants: R0..R15 = 0..15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, C=23
  - mode constants MODE_PRIO=0, MODE_RR=1
- One sub-module, rr_priority_picker (parameters NSRC, SELW):
  - combinational
  - inputs: request vector, pointer, mode
  - outputs: one-hot winner, encoded index, any, multi
- The top-level holds the registers, the source slice mux, the counter and the pointer.

## Test plan
- Reset: assert clear asynchronously mid-cycle with src_out=24'h000001 -> all outputs zero immediately, rr_ptr=23. After release, the next edge gives grant=1, sel=0.
- Single driver / hold:
  - src_out=1<<20, src_data[PC]=32'h0000_0040 -> after one edge bus_out=0x40, bus_valid=1, sel=20.
  - Then src_out=0 for 3 cycles -> bus_out stays 0x40, bus_valid=0, grant=0.
- Priority conflict: mode=0, src_out bits 3 and 17 set -> sel=3, bus_out=src_data[3], conflict pulses one cycle, conflict_count=1.
- Round-robin rotation and wrap: mode=1, bits 0, 5 and 23 held set for 4 cycles from reset -> sel sequence 0, 5, 23, 0; conflict high all 4 cycles; count=4.
- Saturation and clear:
  - Force 300 conflicting cycles -> count stays 255, with conflict still pulsing.
  - cnt_clr together with a conflict -> count=0, conflict=1.
- Mode switch: after an RR grant to 5, switch to mode 0 with bits 2 and 9 set -> sel=2. Switch back to mode 1 with the same requests -> sel=9 (pointer was 2).
